cmd_initiator: RTL and testbench

- Host-side command master; the counterpart of the board command FSM that collects verb/arg1/arg2/arg3 bytes and answers with one response byte.
- Accepts a 4-byte command on a parallel port and serialises it in the order verb, arg1, arg2, arg3 through a byte-level UART transmitter handshake.
- Then waits for a single response byte from the UART receiver, with timeout and automatic full-command retry.
- Used in the loopback test harness and in the Mbed-replacement controller.

---
 rtl/cmd_initiator.sv | 172 +++++++++++++++++
 tb/tb_cmd_initiator.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_initiator.sv
// Host-side command master: sends verb/arg1/arg2/arg3 over a UART byte handshake, awaits one reply.
// Optional CMD_ECHO_CHECK_EN: only a reply equal to the verb is accepted; others force a retry.
module cmd_initiator #(
    parameter int TIMEOUT_CYCLES = 5000000,
    parameter int MAX_RETRIES    = 2,
    parameter int CNT_W          = 23
) (
    input  logic       clk50m,
    input  logic       reset,
    input  logic       cmd_start,
    input  logic [7:0] cmd_verb,
    input  logic [7:0] cmd_arg1,
    input  logic [7:0] cmd_arg2,
    input  logic [7:0] cmd_arg3,
    output logic       cmd_ready,
    output logic [7:0] tx_data,
    output logic       tx_start,
    input  logic       tx_busy,
    input  logic [7:0] rx_data,
    input  logic       rx_ready,
    output logic [7:0] resp_data,
    output logic       resp_valid,
    output logic       timeout_err,
    output logic [2:0] state_out
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SEND      = 3'd1,
        WAIT_TX   = 3'd2,
        WAIT_RESP = 3'd3,
        DONE      = 3'd4,
        ERR       = 3'd5
    } state_t;

    localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam logic [RW-1:0]    RMAX  = RW'(MAX_RETRIES);
    localparam logic [CNT_W-1:0] TLAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state, next;
    logic [7:0]       verb_q, arg1_q, arg2_q, arg3_q;
    logic [1:0]       idx;
    logic [RW-1:0]    retry;
    logic [CNT_W-1:0] timer;
    logic             res;
    logic [7:0]       tx_q;
    logic [7:0]       resp_q;
    logic [7:0]       cur_byte;
    logic             resp_hit, resp_bad, timed_out;
    logic             load, launch, adv, arm, retry_go, capture;

    always_comb begin
        cur_byte = verb_q;
        unique case (idx)
            2'd0: cur_byte = verb_q;
            2'd1: cur_byte = arg1_q;
            2'd2: cur_byte = arg2_q;
            2'd3: cur_byte = arg3_q;
        endcase
    end

`ifdef CMD_ECHO_CHECK_EN
    assign resp_hit = rx_ready && (rx_data == verb_q);
    assign resp_bad = rx_ready && (rx_data != verb_q);
`else
    assign resp_hit = rx_ready;
    assign resp_bad = 1'b0;
`endif

    // A rejected echo is handled exactly like an expired timer
    assign timed_out = (timer == TLAST) || resp_bad;

    always_ff @(posedge clk50m or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next;
    end

    always_comb begin
        next     = state;
        load     = 1'b0;
        launch   = 1'b0;
        adv      = 1'b0;
        arm      = 1'b0;
        retry_go = 1'b0;
        capture  = 1'b0;
        unique case (state)
            IDLE: begin
                if (cmd_start) begin
                    load = 1'b1;
                    next = SEND;
                end
            end
            SEND: begin
                if (!tx_busy) begin
                    launch = 1'b1;
                    next   = WAIT_TX;
                end
            end
            WAIT_TX: begin
                if (res && !tx_busy) begin
                    if (idx == 2'd3) begin
                        arm  = 1'b1;
                        next = WAIT_RESP;
                    end else begin
                        adv  = 1'b1;
                        next = SEND;
                    end
                end
            end
            WAIT_RESP: begin
                if (resp_hit) begin
                    capture = 1'b1;
                    next    = DONE;
                end else if (timed_out) begin
                    if (retry < RMAX) begin
                        retry_go = 1'b1;
                        next     = SEND;
                    end else begin
                        next = ERR;
                    end
                end
            end
            DONE:    next = IDLE;
            ERR:     next = IDLE;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk50m or negedge reset) begin
        if (!reset) begin
            verb_q <= '0;
            arg1_q <= '0;
            arg2_q <= '0;
            arg3_q <= '0;
            idx    <= '0;
            retry  <= '0;
            timer  <= '0;
            res    <= 1'b0;
            tx_q   <= '0;
            resp_q <= '0;
        end else begin
            // res marks the second and later cycles spent in WAIT_TX
            res <= (state == WAIT_TX);
            if (load) begin
                verb_q <= cmd_verb;
                arg1_q <= cmd_arg1;
                arg2_q <= cmd_arg2;
                arg3_q <= cmd_arg3;
                idx    <= '0;
                retry  <= '0;
            end
            if (launch)   tx_q <= cur_byte;
            if (adv)      idx  <= idx + 2'd1;
            if (arm)      timer <= '0;
            else if (state == WAIT_RESP) timer <= timer + 1'b1;
            if (retry_go) begin
                retry <= retry + 1'b1;
                idx   <= '0;
            end
            if (capture)  resp_q <= rx_data;
        end
    end

    assign cmd_ready   = (state == IDLE);
    assign tx_start    = launch;
    assign tx_data     = launch ? cur_byte : tx_q;
    assign resp_data   = resp_q;
    assign resp_valid  = (state == DONE);
    assign timeout_err = (state == ERR);
    assign state_out   = state;

endmodule

// File: tb/tb_cmd_initiator.sv
// Directed bench for cmd_initiator with a 10-cycle busy transmitter model.
module tb_cmd_initiator;

    logic       clk50m = 1'b0;
    logic       reset = 1'b0;
    logic       cmd_start = 1'b0;
    logic [7:0] cmd_verb = '0, cmd_arg1 = '0, cmd_arg2 = '0, cmd_arg3 = '0;
    logic       cmd_ready;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;
    logic [7:0] rx_data = '0;
    logic       rx_ready = 1'b0;
    logic [7:0] resp_data;
    logic       resp_valid;
    logic       timeout_err;
    logic [2:0] state_out;

    int compared = 0;
    int mismatched = 0;

    cmd_initiator #(
        .TIMEOUT_CYCLES(100),
        .MAX_RETRIES(2),
        .CNT_W(23)
    ) dut (
        .clk50m(clk50m), .reset(reset), .cmd_start(cmd_start),
        .cmd_verb(cmd_verb), .cmd_arg1(cmd_arg1),
        .cmd_arg2(cmd_arg2), .cmd_arg3(cmd_arg3),
        .cmd_ready(cmd_ready), .tx_data(tx_data), .tx_start(tx_start),
        .tx_busy(tx_busy), .rx_data(rx_data), .rx_ready(rx_ready),
        .resp_data(resp_data), .resp_valid(resp_valid),
        .timeout_err(timeout_err), .state_out(state_out)
    );

    always #10 clk50m = ~clk50m;

    // Transmitter model: busy for 10 cycles starting the cycle after tx_start
    logic pend = 1'b0;
    int   busy_cnt = 0;
    assign tx_busy = (busy_cnt != 0);
    always @(negedge clk50m) pend <= tx_start;
    always @(posedge clk50m) begin
        if (pend) busy_cnt <= 10;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end

    // Monitor
    int cyc = 0;
    int n_start = 0, n_valid = 0, n_err = 0;
    int last_start_cyc = 0, err_cyc = 0;
    logic [7:0] blog [0:15];
    always @(negedge clk50m) begin
        cyc = cyc + 1;
        if (tx_start) begin
            if (n_start < 16) blog[n_start] = tx_data;
            n_start = n_start + 1;
            last_start_cyc = cyc;
        end
        if (resp_valid) n_valid = n_valid + 1;
        if (timeout_err) begin
            n_err = n_err + 1;
            err_cyc = cyc;
        end
    end

    task automatic tick();
        @(negedge clk50m);
        #1;
    endtask

    task automatic clr();
        n_start = 0;
        n_valid = 0;
        n_err = 0;
    endtask

    task automatic wait_state(input logic [2:0] s, input int lim, input string nm);
        int k;
        k = 0;
        while (state_out !== s && k < lim) begin
            tick();
            k++;
        end
        compared++;
        if (state_out !== s) begin
            mismatched++;
            $display("FAIL %s: state %0d, wanted %0d within %0d cycles", nm, state_out, s, lim);
        end
    endtask

    task automatic issue(input logic [7:0] v, a1, a2, a3);
        cmd_verb = v; cmd_arg1 = a1; cmd_arg2 = a2; cmd_arg3 = a3;
        cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
    endtask

    task automatic reply(input logic [7:0] d);
        rx_data = d;
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) tick();
        compared += 7;
        if (cmd_ready !== 1'b1) begin mismatched++; $display("FAIL rst_ready: %b want 1", cmd_ready); end
        if (tx_start !== 1'b0) begin mismatched++; $display("FAIL rst_txs: %b want 0", tx_start); end
        if (tx_data !== 8'h00) begin mismatched++; $display("FAIL rst_txd: %h want 00", tx_data); end
        if (resp_data !== 8'h00) begin mismatched++; $display("FAIL rst_resp: %h want 00", resp_data); end
        if (resp_valid !== 1'b0) begin mismatched++; $display("FAIL rst_valid: %b want 0", resp_valid); end
        if (timeout_err !== 1'b0) begin mismatched++; $display("FAIL rst_err: %b want 0", timeout_err); end
        if (state_out !== 3'd0) begin mismatched++; $display("FAIL rst_state: %0d want 0", state_out); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        clr();
        issue(8'h02, 8'h11, 8'h22, 8'h33);
        compared++;
        if (tx_start !== 1'b1 || tx_data !== 8'h02) begin
            mismatched++;
            $display("FAIL basic_latency: start=%b data=%h want 1/02", tx_start, tx_data);
        end
        wait_state(3'd3, 200, "basic_wait_resp");
        repeat (5) tick();
        reply(8'h02);
        wait_state(3'd0, 20, "basic_idle");
        compared += 7;
        if (n_start !== 4) begin mismatched++; $display("FAIL basic_nstart: %0d want 4", n_start); end
        if (blog[0] !== 8'h02) begin mismatched++; $display("FAIL basic_b0: %h want 02", blog[0]); end
        if (blog[1] !== 8'h11) begin mismatched++; $display("FAIL basic_b1: %h want 11", blog[1]); end
        if (blog[2] !== 8'h22) begin mismatched++; $display("FAIL basic_b2: %h want 22", blog[2]); end
        if (blog[3] !== 8'h33) begin mismatched++; $display("FAIL basic_b3: %h want 33", blog[3]); end
        if (n_valid !== 1 || n_err !== 0) begin
            mismatched++;
            $display("FAIL basic_pulses: valid=%0d err=%0d want 1/0", n_valid, n_err);
        end
        if (resp_data !== 8'h02) begin mismatched++; $display("FAIL basic_resp: %h want 02", resp_data); end
    endtask

    task automatic test_ignore();
        clr();
        issue(8'h02, 8'h11, 8'h22, 8'h33);
        reply(8'h55);
        compared++;
        if (resp_data !== 8'h02) begin mismatched++; $display("FAIL ign_resp: %h want 02", resp_data); end
        wait_state(3'd2, 20, "ign_wait_tx");
        compared++;
        if (cmd_ready !== 1'b0) begin mismatched++; $display("FAIL ign_ready: %b want 0", cmd_ready); end
        issue(8'hA0, 8'hA1, 8'hA2, 8'hA3);
        wait_state(3'd3, 200, "ign_wait_resp");
        reply(8'h02);
        wait_state(3'd0, 20, "ign_idle");
        compared += 3;
        if (n_start !== 4) begin mismatched++; $display("FAIL ign_nstart: %0d want 4", n_start); end
        if (blog[1] !== 8'h11 || blog[3] !== 8'h33) begin
            mismatched++;
            $display("FAIL ign_bytes: %h %h want 11 33", blog[1], blog[3]);
        end
        if (n_valid !== 1) begin mismatched++; $display("FAIL ign_valid: %0d want 1", n_valid); end
    endtask

    task automatic test_retry_success();
        int k;
        clr();
        issue(8'h02, 8'h44, 8'h55, 8'h66);
        k = 0;
        while (n_start < 5 && k < 400) begin tick(); k++; end
        wait_state(3'd3, 200, "rs_wait_resp");
        repeat (3) tick();
        reply(8'h02);
        wait_state(3'd0, 20, "rs_idle");
        compared += 3;
        if (n_start !== 8) begin mismatched++; $display("FAIL rs_nstart: %0d want 8", n_start); end
        if (n_valid !== 1) begin mismatched++; $display("FAIL rs_valid: %0d want 1", n_valid); end
        if (n_err !== 0) begin mismatched++; $display("FAIL rs_err: %0d want 0", n_err); end
    endtask

    task automatic test_timeout();
        clr();
        issue(8'h09, 8'h01, 8'h02, 8'h03);
        tick();
        wait_state(3'd0, 1000, "to_idle");
        compared += 5;
        if (n_start !== 12) begin mismatched++; $display("FAIL to_nstart: %0d want 12", n_start); end
        if (n_err !== 1) begin mismatched++; $display("FAIL to_err: %0d want 1", n_err); end
        if (n_valid !== 0) begin mismatched++; $display("FAIL to_valid: %0d want 0", n_valid); end
        if (resp_data !== 8'h02) begin mismatched++; $display("FAIL to_resp: %h want 02", resp_data); end
        if (err_cyc - last_start_cyc !== 112) begin
            mismatched++;
            $display("FAIL to_delay: %0d want 112", err_cyc - last_start_cyc);
        end
    endtask

    task automatic test_echo();
        clr();
        issue(8'h02, 8'h10, 8'h20, 8'h30);
        wait_state(3'd3, 200, "echo_wait_resp");
        reply(8'h7F);
`ifdef CMD_ECHO_CHECK_EN
        compared++;
        if (state_out !== 3'd1) begin mismatched++; $display("FAIL echo_retry: %0d want 1", state_out); end
        wait_state(3'd0, 1000, "echo_idle");
        compared += 3;
        if (n_err !== 1) begin mismatched++; $display("FAIL echo_err: %0d want 1", n_err); end
        if (n_valid !== 0) begin mismatched++; $display("FAIL echo_valid: %0d want 0", n_valid); end
        if (resp_data !== 8'h02) begin mismatched++; $display("FAIL echo_resp: %h want 02", resp_data); end
`else
        wait_state(3'd0, 20, "echo_idle");
        compared += 2;
        if (n_valid !== 1) begin mismatched++; $display("FAIL echo_valid: %0d want 1", n_valid); end
        if (resp_data !== 8'h7F) begin mismatched++; $display("FAIL echo_resp: %h want 7f", resp_data); end
`endif
    endtask

    task automatic test_reset_mid();
        int k;
        clr();
        issue(8'h02, 8'h11, 8'h22, 8'h33);
        k = 0;
        while (n_start < 3 && k < 200) begin tick(); k++; end
        wait_state(3'd2, 20, "rm_wait_tx");
        reset = 1'b0;
        #1;
        compared += 3;
        if (tx_start !== 1'b0) begin mismatched++; $display("FAIL rm_txs: %b want 0", tx_start); end
        if (cmd_ready !== 1'b1) begin mismatched++; $display("FAIL rm_ready: %b want 1", cmd_ready); end
        if (state_out !== 3'd0) begin mismatched++; $display("FAIL rm_state: %0d want 0", state_out); end
        tick();
        reset = 1'b1;
        repeat (40) tick();
        compared += 2;
        if (n_start !== 3) begin mismatched++; $display("FAIL rm_nstart: %0d want 3", n_start); end
        if (state_out !== 3'd0) begin mismatched++; $display("FAIL rm_idle: %0d want 0", state_out); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ignore();
        test_retry_success();
        test_timeout();
        test_echo();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
